// File: rtl/gfx_pixel_sequencer_if.sv
// gfx_pixel_sequencer_if
// Bundles the graphics-sequencer input/output bus so the pixel sequencer
// and its upstream/downstream neighbours share one connection point.
//
// Handshake: there is no valid/ready pair on this bus. dot_rising is a
// one-cycle strobe per pixel; every input is sampled only on a clk_dot4x
// edge where dot_rising is high. pixel_color/pixel_fg are registered and
// hold their value between strobes. There is no backpressure.
//
// Signals:
//   dot_rising   strobe, one pulse per pixel
//   xpos_lsb     pixel index within the 8-pixel cell
//   xscroll      fine horizontal scroll
//   pixels_read  graphics byte (bit 7 = leftmost pixel)
//   char_read    {colour nibble, char/screen byte}
//   ecm/bmm/mcm  display mode bits
//   b0c..b3c     background colour registers
//   pixel_color  colour index of the current dot
//   pixel_fg     foreground flag of the current dot
// Modports: master = upstream/driver side, slave = pixel sequencer.
interface gfx_pixel_sequencer_if #(
  parameter int COLOR_W = 4
);
  logic               dot_rising;
  logic [2:0]         xpos_lsb;
  logic [2:0]         xscroll;
  logic [7:0]         pixels_read;
  logic [11:0]        char_read;
  logic               ecm;
  logic               bmm;
  logic               mcm;
  logic [COLOR_W-1:0] b0c;
  logic [COLOR_W-1:0] b1c;
  logic [COLOR_W-1:0] b2c;
  logic [COLOR_W-1:0] b3c;
  logic [COLOR_W-1:0] pixel_color;
  logic               pixel_fg;

  modport master (
    output dot_rising, xpos_lsb, xscroll, pixels_read, char_read,
    output ecm, bmm, mcm, b0c, b1c, b2c, b3c,
    input  pixel_color, pixel_fg
  );

  modport slave (
    input  dot_rising, xpos_lsb, xscroll, pixels_read, char_read,
    input  ecm, bmm, mcm, b0c, b1c, b2c, b3c,
    output pixel_color, pixel_fg
  );
endinterface

// File: rtl/gfx_pixel_sequencer.sv
// gfx_pixel_sequencer
// Aligns each fetched graphics byte to the fine horizontal scroll, shifts
// it out one dot at a time and decodes the five VIC-II display modes into a
// per-dot colour index plus a foreground flag.
//
// Ports:
//   clk_dot4x  system clock (4x dot clock)
//   rst        synchronous active-high reset
//   bus        gfx_pixel_sequencer_if.slave (inputs, pixel_color, pixel_fg)
//
// Optional feature (macro GFX_COLOR_REG_DELAY_EN): when defined, b0c..b3c
// pass through a register updated on dot_rising, so a background colour
// write is seen by the decode one dot later. Undefined: used directly.
module gfx_pixel_sequencer #(
  parameter int COLOR_W = 4
) (
  input logic                  clk_dot4x,
  input logic                  rst,
  gfx_pixel_sequencer_if.slave bus
);

  logic [7:0]         shifter, shifter_nxt;
  logic [11:0]        attr, attr_nxt;
  logic               mc_phase, mc_phase_nxt;
  logic [COLOR_W-1:0] color_q, color_nxt;
  logic               fg_q, fg_nxt;
  logic [COLOR_W-1:0] bg0, bg1, bg2, bg3;
  logic               load;
  logic               mc_shift;
  logic               mc_dec;
  logic               pix_b;
  logic [1:0]         pix_p;

`ifdef GFX_COLOR_REG_DELAY_EN
  logic [COLOR_W-1:0] b0c_q, b1c_q, b2c_q, b3c_q;

  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      b0c_q <= '0;
      b1c_q <= '0;
      b2c_q <= '0;
      b3c_q <= '0;
    end else if (bus.dot_rising) begin
      b0c_q <= bus.b0c;
      b1c_q <= bus.b1c;
      b2c_q <= bus.b2c;
      b3c_q <= bus.b3c;
    end
  end

  assign bg0 = b0c_q;
  assign bg1 = b1c_q;
  assign bg2 = b2c_q;
  assign bg3 = b3c_q;
`else
  assign bg0 = bus.b0c;
  assign bg1 = bus.b1c;
  assign bg2 = bus.b2c;
  assign bg3 = bus.b3c;
`endif

  assign load = bus.dot_rising && (bus.xpos_lsb == bus.xscroll);

  // Multicolour is re-evaluated every dot from the live mcm bit and the
  // latched attribute, so a mid-cell mcm change takes effect immediately.
  assign mc_shift = bus.mcm && (bus.bmm || attr[11]);

  always_comb begin
    shifter_nxt  = shifter;
    attr_nxt     = attr;
    mc_phase_nxt = mc_phase;
    if (load) begin
      // A load aborts any half-shown multicolour pair.
      shifter_nxt  = bus.pixels_read;
      attr_nxt     = bus.char_read;
      mc_phase_nxt = 1'b0;
    end else if (bus.dot_rising) begin
      mc_phase_nxt = ~mc_phase;
      if (!mc_shift) begin
        shifter_nxt = {shifter[6:0], 1'b0};
      end else if (mc_phase) begin
        shifter_nxt = {shifter[5:0], 2'b00};
      end
    end
  end

  // Decode looks at the post-load/post-shift value so the load dot already
  // shows pixels_read[7].
  assign pix_b  = shifter_nxt[7];
  assign pix_p  = shifter_nxt[7:6];
  assign mc_dec = bus.mcm && (bus.bmm || attr_nxt[11]);

  function automatic logic [COLOR_W-1:0] pick_bg(input logic [1:0] sel,
      input logic [COLOR_W-1:0] c0, input logic [COLOR_W-1:0] c1,
      input logic [COLOR_W-1:0] c2, input logic [COLOR_W-1:0] c3);
    logic [COLOR_W-1:0] r;
    case (sel)
      2'd0:    r = c0;
      2'd1:    r = c1;
      2'd2:    r = c2;
      default: r = c3;
    endcase
    return r;
  endfunction

  always_comb begin
    color_nxt = '0;
    case ({bus.ecm, bus.bmm, bus.mcm})
      3'b000: color_nxt = pix_b ? COLOR_W'(attr_nxt[11:8]) : bg0;
      3'b001: begin
        if (attr_nxt[11]) begin
          color_nxt = (pix_p == 2'b11) ? COLOR_W'({1'b0, attr_nxt[10:8]})
                                       : pick_bg(pix_p, bg0, bg1, bg2, bg3);
        end else begin
          color_nxt = pix_b ? COLOR_W'({1'b0, attr_nxt[10:8]}) : bg0;
        end
      end
      3'b010: color_nxt = pix_b ? COLOR_W'(attr_nxt[7:4]) : COLOR_W'(attr_nxt[3:0]);
      3'b011: begin
        case (pix_p)
          2'b00:   color_nxt = bg0;
          2'b01:   color_nxt = COLOR_W'(attr_nxt[7:4]);
          2'b10:   color_nxt = COLOR_W'(attr_nxt[3:0]);
          default: color_nxt = COLOR_W'(attr_nxt[11:8]);
        endcase
      end
      3'b100: color_nxt = pix_b ? COLOR_W'(attr_nxt[11:8])
                                : pick_bg(attr_nxt[7:6], bg0, bg1, bg2, bg3);
      default: color_nxt = '0;
    endcase
    // Foreground follows the non-ECM equivalent mode even when invalid.
    fg_nxt = mc_dec ? pix_p[1] : pix_b;
  end

  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      shifter  <= '0;
      attr     <= '0;
      mc_phase <= 1'b0;
      color_q  <= '0;
      fg_q     <= 1'b0;
    end else if (bus.dot_rising) begin
      shifter  <= shifter_nxt;
      attr     <= attr_nxt;
      mc_phase <= mc_phase_nxt;
      color_q  <= color_nxt;
      fg_q     <= fg_nxt;
    end
  end

  assign bus.pixel_color = color_q;
  assign bus.pixel_fg    = fg_q;

endmodule

// File: tb/tb_gfx_pixel_sequencer.sv
module tb_gfx_pixel_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gfx_pixel_sequencer_if #(.COLOR_W(4)) bus_if ();

  gfx_pixel_sequencer #(.COLOR_W(4)) dut (
    .clk_dot4x (clk),
    .rst       (rst),
    .bus       (bus_if)
  );

  int total = 0;
  int bad   = 0;
  logic [2:0] xpos = 3'd0;

  // ---------------- reference model state ----------------
  // The model remembers the loaded byte and how many bit positions have been
  // consumed since the load, instead of keeping a shift register.
  logic [7:0]  m_byte;
  logic [11:0] m_attr;
  int          m_pos;
  int          m_cnt;
  logic [3:0]  m_color;
  logic        m_fg;
  logic [3:0]  m_bgq [4];

  // Directed expectations: {fg, color}
  logic [4:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] bg [4];
    logic [7:0] v;
    logic       b;
    logic [1:0] p;
    logic [3:0] cc, hi, lo;
    logic       mcf;
    if (rst) begin
      m_byte = '0; m_attr = '0; m_pos = 0; m_cnt = 0;
      m_color = '0; m_fg = 1'b0;
      m_bgq = '{default: 4'd0};
      return;
    end
    if (!bus_if.dot_rising) return;
`ifdef GFX_COLOR_REG_DELAY_EN
    bg = m_bgq;
    m_bgq = '{bus_if.b0c, bus_if.b1c, bus_if.b2c, bus_if.b3c};
`else
    bg = '{bus_if.b0c, bus_if.b1c, bus_if.b2c, bus_if.b3c};
`endif
    if (bus_if.xpos_lsb == bus_if.xscroll) begin
      m_byte = bus_if.pixels_read;
      m_attr = bus_if.char_read;
      m_pos  = 0;
      m_cnt  = 0;
    end else begin
      // multicolour consumes a pair on every second dot after the load
      if (bus_if.mcm && (bus_if.bmm || m_attr[11]))
        m_pos += ((m_cnt % 2) == 1) ? 2 : 0;
      else
        m_pos += 1;
      m_cnt++;
    end
    v   = (m_pos >= 8) ? 8'h00 : 8'(m_byte << m_pos);
    b   = v[7];
    p   = v[7:6];
    cc  = m_attr[11:8];
    hi  = m_attr[7:4];
    lo  = m_attr[3:0];
    mcf = bus_if.mcm && (bus_if.bmm || m_attr[11]);
    if (bus_if.ecm && (bus_if.bmm || bus_if.mcm)) m_color = 4'd0;
    else if (bus_if.ecm)                          m_color = b ? cc : bg[m_attr[7:6]];
    else if (bus_if.bmm && bus_if.mcm)
      m_color = (p == 2'd0) ? bg[0] : (p == 2'd1) ? hi : (p == 2'd2) ? lo : cc;
    else if (bus_if.bmm)                          m_color = b ? hi : lo;
    else if (bus_if.mcm && m_attr[11])            m_color = (p == 2'd3) ? {1'b0, cc[2:0]} : bg[p];
    else if (bus_if.mcm)                          m_color = b ? {1'b0, cc[2:0]} : bg[0];
    else                                          m_color = b ? cc : bg[0];
    m_fg = mcf ? p[1] : b;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit dr, input bit r);
    @(negedge clk);
    bus_if.dot_rising = dr;
    bus_if.xpos_lsb   = xpos;
    rst               = r;
    @(posedge clk);
    #1;
    model_step();
    check("model_color", 16'(bus_if.pixel_color), 16'(m_color));
    check("model_fg",    16'(bus_if.pixel_fg),    16'(m_fg));
    if (dr) xpos++;
  endtask

  task automatic dot(input int idle);
    logic [4:0] e;
    cycle(1'b1, 1'b0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("dir_color", 16'(bus_if.pixel_color), 16'(e[3:0]));
      check("dir_fg",    16'(bus_if.pixel_fg),    16'(e[4]));
    end
    for (int k = 0; k < idle; k++) cycle(1'b0, 1'b0);
  endtask

  task automatic set_mode(input logic e, input logic bm, input logic mc);
    bus_if.ecm = e; bus_if.bmm = bm; bus_if.mcm = mc;
  endtask

  task automatic push_seq(input logic [3:0] c[8], input logic f[8]);
    for (int k = 0; k < 8; k++) exp_q.push_back({f[k], c[k]});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus_if.dot_rising = 0; bus_if.xpos_lsb = 0; bus_if.xscroll = 0;
    bus_if.pixels_read = 0; bus_if.char_read = 0;
    set_mode(0, 0, 0);
    bus_if.b0c = 0; bus_if.b1c = 0; bus_if.b2c = 0; bus_if.b3c = 0;
    rst = 1'b1;

    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    check("reset_color", 16'(bus_if.pixel_color), 16'd0);
    check("reset_fg",    16'(bus_if.pixel_fg),    16'd0);

    // standard text, xscroll=0
    xpos = 3'd0;
    bus_if.b0c = 4'd6; bus_if.b1c = 4'd1; bus_if.b2c = 4'd3; bus_if.b3c = 4'd8;
    bus_if.pixels_read = 8'hA5; bus_if.char_read = 12'h700;
    cycle(1'b0, 1'b0);
    push_seq('{7, 6, 7, 6, 6, 7, 6, 7}, '{1, 0, 1, 0, 0, 1, 0, 1});
    for (int i = 0; i < 8; i++) dot($urandom_range(0, 3));

    // same byte, xscroll=3: drained shifter shows b0c before the load
    bus_if.xscroll = 3'd3;
    exp_q.push_back({1'b0, 4'd6}); exp_q.push_back({1'b0, 4'd6});
    exp_q.push_back({1'b0, 4'd6}); exp_q.push_back({1'b1, 4'd7});
    for (int i = 0; i < 8; i++) dot($urandom_range(0, 3));

    // multicolour bitmap
    bus_if.xscroll = 3'd0;
    set_mode(0, 1, 1);
    bus_if.b0c = 4'd0;
    bus_if.pixels_read = 8'b00_01_10_11; bus_if.char_read = 12'h942;
    push_seq('{0, 0, 4, 4, 2, 2, 9, 9}, '{0, 0, 0, 0, 1, 1, 1, 1});
    for (int i = 0; i < 8; i++) dot($urandom_range(0, 3));

    // multicolour text with attr[11]=0 behaves as hires
    set_mode(0, 0, 1);
    bus_if.b0c = 4'd6;
    bus_if.pixels_read = 8'h80; bus_if.char_read = 12'h500;
    push_seq('{5, 6, 6, 6, 6, 6, 6, 6}, '{1, 0, 0, 0, 0, 0, 0, 0});
    for (int i = 0; i < 8; i++) dot($urandom_range(0, 3));

    // extended colour text, background selected by attr[7:6]=2
    set_mode(1, 0, 0);
    bus_if.b2c = 4'hE;
    bus_if.pixels_read = 8'h00; bus_if.char_read = 12'h080;
    push_seq('{14, 14, 14, 14, 14, 14, 14, 14}, '{0, 0, 0, 0, 0, 0, 0, 0});
    for (int i = 0; i < 8; i++) dot($urandom_range(0, 3));
    // invalid mode ECM+BMM
    set_mode(1, 1, 0);
    exp_q.push_back({1'b0, 4'd0}); exp_q.push_back({1'b0, 4'd0});
    for (int i = 0; i < 2; i++) dot($urandom_range(0, 3));

    // reset mid-cell after three dots
    set_mode(0, 0, 0);
    bus_if.b0c = 4'd6;
    bus_if.pixels_read = 8'hA5; bus_if.char_read = 12'h700;
    bus_if.xscroll = xpos;
    exp_q.push_back({1'b1, 4'd7}); exp_q.push_back({1'b0, 4'd6});
    exp_q.push_back({1'b1, 4'd7});
    for (int i = 0; i < 3; i++) dot($urandom_range(0, 3));
    cycle(1'b1, 1'b1);
    check("rst_mid_color", 16'(bus_if.pixel_color), 16'd0);
    check("rst_mid_fg",    16'(bus_if.pixel_fg),    16'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 4'd6});
    for (int i = 0; i < 4; i++) dot($urandom_range(0, 3));

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        bus_if.ecm = ($urandom_range(0, 3) == 0);
        bus_if.bmm = 1'($urandom_range(0, 1));
        bus_if.mcm = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 15) == 0) begin
        bus_if.b0c = 4'($urandom); bus_if.b1c = 4'($urandom);
        bus_if.b2c = 4'($urandom); bus_if.b3c = 4'($urandom);
      end
      if ($urandom_range(0, 29) == 0) bus_if.xscroll = 3'($urandom);
      bus_if.pixels_read = 8'($urandom);
      bus_if.char_read   = 12'($urandom);
      if ($urandom_range(0, 99) == 0) cycle(1'($urandom_range(0, 1)), 1'b1);
      else dot($urandom_range(0, 2));
    end

    check("dir_queue_empty", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
